// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit: valid/ready core side and memory side, lane steering, extension, misalign check
// Optional feature macro: LSU_TIMEOUT_EN (bounds the WAIT state to TIMEOUT cycles, then returns an error response)
module lsu_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  // A zero timeout would make WAIT meaningless
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("lsu_ctrl: TIMEOUT must be at least 1");
  end

  state_t      r_state;
  logic        r_wen;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_mem_req_valid;
  logic        r_mem_wen;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wmask;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

`ifdef LSU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo_cnt;
`endif

  logic        w_misaligned;
  logic [4:0]  w_wshamt;
  logic [31:0] w_wdata_sh;
  logic [3:0]  w_wmask;
  logic [4:0]  w_rshamt;
  logic [15:0] w_lane;
  logic [31:0] w_load;

  // Decode the incoming request: alignment, shifted store data and byte mask
  always_comb begin
    w_wshamt     = {req_addr[1:0], 3'b000};
    w_wdata_sh   = req_wdata << w_wshamt;
    w_wmask      = 4'b0000;
    w_misaligned = 1'b0;
    case (req_size)
      2'b00: w_wmask = 4'b0001 << req_addr[1:0];
      2'b01: begin
        w_wmask      = 4'b0011 << req_addr[1:0];
        w_misaligned = req_addr[0];
      end
      2'b10: begin
        w_wmask      = 4'b1111;
        w_misaligned = (req_addr[1:0] != 2'b00);
      end
      default: w_misaligned = 1'b1;
    endcase
  end

  // Extract and extend the load lane from the returned bus word
  always_comb begin
    w_rshamt = {r_off, 3'b000};
    w_lane   = 16'(mem_rdata >> w_rshamt);
    case (r_size)
      2'b00:   w_load = r_unsigned ? {24'h0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
      2'b01:   w_load = r_unsigned ? {16'h0, w_lane} : {{16{w_lane[15]}}, w_lane};
      default: w_load = mem_rdata;
    endcase
  end

  // Main FSM; every output is a register updated here
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_wen           <= 1'b0;
      r_off           <= 2'b00;
      r_size          <= 2'b00;
      r_unsigned      <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_mem_wen       <= 1'b0;
      r_mem_addr      <= 32'h0;
      r_mem_wdata     <= 32'h0;
      r_mem_wmask     <= 4'h0;
      r_resp_valid    <= 1'b0;
      r_resp_err      <= 1'b0;
      r_resp_rdata    <= 32'h0;
`ifdef LSU_TIMEOUT_EN
      r_tmo_cnt       <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_wen        <= req_wen;
            r_off        <= req_addr[1:0];
            r_size       <= req_size;
            r_unsigned   <= req_unsigned;
            r_resp_rdata <= 32'h0;
            if (w_misaligned) begin
              // Error straight to the core, the bus is never touched
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_resp_err      <= 1'b0;
              r_mem_req_valid <= 1'b1;
              r_mem_wen       <= req_wen;
              r_mem_addr      <= {req_addr[31:2], 2'b00};
              r_mem_wdata     <= w_wdata_sh;
              r_mem_wmask     <= req_wen ? w_wmask : 4'h0;
              r_state         <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= WAIT;
`ifdef LSU_TIMEOUT_EN
            r_tmo_cnt       <= '0;
`endif
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            r_resp_rdata <= r_wen ? 32'h0 : w_load;
            r_resp_err   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
`ifdef LSU_TIMEOUT_EN
          else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Held low while reset is asserted even though the state register already reads IDLE
  assign req_ready     = (r_state == IDLE) && !rst;
  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_resp_rdata;
  assign resp_err      = r_resp_err;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_wen       = r_mem_wen;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_wmask     = {4'h0, r_mem_wmask};

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed scoreboard bench for lsu_ctrl
module tb_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  lsu_ctrl #(.TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wen       (req_wen),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; bad=1 means the LSU must reject it without a bus access
  task automatic txn(input string tag, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                     input logic [31:0] bus_rd, input logic bad,
                     input logic [31:0] exp_maddr, input logic [31:0] exp_mwdata,
                     input logic [7:0] exp_mask, input int mstall, input int rstall,
                     input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    exp_t got;
    @(negedge clk);
    chk({tag, ":req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_wen      = wen;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    e.rdata      = exp_rdata;
    e.err        = exp_err;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'hA5A5_A5A5;
    if (bad) begin
      chk({tag, ":no_bus_req"}, 32'(mem_req_valid), 32'd0);
    end else begin
      for (int i = 0; i <= mstall; i++) begin
        chk({tag, ":mem_req_valid"}, 32'(mem_req_valid), 32'd1);
        chk({tag, ":mem_addr"}, mem_addr, exp_maddr);
        chk({tag, ":mem_wen"}, 32'(mem_wen), 32'(wen));
        chk({tag, ":mem_wdata"}, mem_wdata, exp_mwdata);
        chk({tag, ":mem_wmask"}, 32'(mem_wmask), 32'(exp_mask));
        chk({tag, ":resp_idle_req"}, 32'(resp_valid), 32'd0);
        mem_req_ready = (i == mstall);
        // A response during REQ must be ignored
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
      end
      mem_req_ready = 1'b0;
      chk({tag, ":wait_no_req"}, 32'(mem_req_valid), 32'd0);
      chk({tag, ":wait_no_resp"}, 32'(resp_valid), 32'd0);
      mem_rsp_valid = 1'b1;
      mem_rdata     = bus_rd;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rdata     = 32'h5A5A_5A5A;
    end
    for (int i = 0; i <= rstall; i++) begin
      chk({tag, ":resp_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ":req_ready_resp"}, 32'(req_ready), 32'd0);
      resp_ready = (i == rstall);
      if (i == rstall) begin
        if (sb.size() == 0) begin
          chk({tag, ":sb_nonempty"}, 32'd0, 32'd1);
        end else begin
          got = sb.pop_front();
          chk({tag, ":resp_rdata"}, resp_rdata, got.rdata);
          chk({tag, ":resp_err"}, 32'(resp_err), 32'(got.err));
        end
      end
      @(negedge clk);
    end
    resp_ready = 1'b0;
    chk({tag, ":resp_done"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_wen       = 1'b0;
    req_addr      = 32'h0;
    req_wdata     = 32'h0;
    req_size      = 2'b00;
    req_unsigned  = 1'b0;
    resp_ready    = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst:req_ready", 32'(req_ready), 32'd0);
    chk("rst:resp_valid", 32'(resp_valid), 32'd0);
    chk("rst:mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst:mem_addr", mem_addr, 32'd0);
    chk("rst:mem_wdata", mem_wdata, 32'd0);
    chk("rst:mem_wmask", 32'(mem_wmask), 32'd0);
    chk("rst:mem_wen", 32'(mem_wen), 32'd0);
    chk("rst:resp_rdata", resp_rdata, 32'd0);
    chk("rst:resp_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_drop:req_ready", 32'(req_ready), 32'd1);

    //   tag          wen   addr           wdata          sz     uns   bus_rd         bad   maddr          mwdata         mask   ms rs exp_rdata     err
    txn("lw_aligned", 1'b0, 32'h8000_0004, 32'h0,         2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h8000_0004, 32'h0,         8'h00, 0, 0, 32'hDEAD_BEEF, 1'b0);
    txn("lb_signed",  1'b0, 32'h8000_0003, 32'h0,         2'b00, 1'b0, 32'h8011_2233, 1'b0, 32'h8000_0000, 32'h0,         8'h00, 0, 0, 32'hFFFF_FF80, 1'b0);
    txn("lbu",        1'b0, 32'h8000_0003, 32'h0,         2'b00, 1'b1, 32'h8011_2233, 1'b0, 32'h8000_0000, 32'h0,         8'h00, 0, 0, 32'h0000_0080, 1'b0);
    txn("sh_off2",    1'b1, 32'h8000_0002, 32'h0000_ABCD, 2'b01, 1'b0, 32'h1111_1111, 1'b0, 32'h8000_0000, 32'hABCD_0000, 8'h0C, 0, 0, 32'h0,         1'b0);
    txn("lw_misalgn", 1'b0, 32'h8000_0006, 32'h0,         2'b10, 1'b0, 32'h0,         1'b1, 32'h0,         32'h0,         8'h00, 0, 0, 32'h0,         1'b1);
    txn("sb_stall",   1'b1, 32'h8000_0101, 32'h1234_5678, 2'b00, 1'b0, 32'h2222_2222, 1'b0, 32'h8000_0100, 32'h3456_7800, 8'h02, 5, 3, 32'h0,         1'b0);
    txn("lh_signed",  1'b0, 32'h8000_000A, 32'h0,         2'b01, 1'b0, 32'hF00D_1234, 1'b0, 32'h8000_0008, 32'h0,         8'h00, 0, 0, 32'hFFFF_F00D, 1'b0);
    txn("lhu_off0",   1'b0, 32'h0000_0040, 32'h0,         2'b01, 1'b1, 32'h1234_8765, 1'b0, 32'h0000_0040, 32'h0,         8'h00, 0, 1, 32'h0000_8765, 1'b0);
    txn("lb_pos",     1'b0, 32'h0000_0041, 32'h0,         2'b00, 1'b0, 32'h0000_7F00, 1'b0, 32'h0000_0040, 32'h0,         8'h00, 1, 0, 32'h0000_007F, 1'b0);
    txn("sw_aligned", 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h3333_3333, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 8'h0F, 0, 0, 32'h0,         1'b0);
    txn("sh_misalgn", 1'b1, 32'h0000_0013, 32'h0000_BEEF, 2'b01, 1'b0, 32'h0,         1'b1, 32'h0,         32'h0,         8'h00, 0, 0, 32'h0,         1'b1);
    txn("size_ill",   1'b0, 32'h0000_0020, 32'h0,         2'b11, 1'b0, 32'h0,         1'b1, 32'h0,         32'h0,         8'h00, 0, 2, 32'h0,         1'b1);

    // Reset while in WAIT; the late bus response must not surface
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = 32'h8000_0010;
    req_size  = 2'b10;
    @(negedge clk);
    req_valid     = 1'b0;
    chk("rstw:mem_req_valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rstw:in_wait", 32'(mem_req_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw:resp_valid", 32'(resp_valid), 32'd0);
    chk("rstw:mem_req_valid_rst", 32'(mem_req_valid), 32'd0);
    chk("rstw:req_ready_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rstw:req_ready_after", 32'(req_ready), 32'd1);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h7777_7777;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("rstw:late_rsp_ignored", 32'(resp_valid), 32'd0);
    chk("rstw:still_idle", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("rstw:no_resp_later", 32'(resp_valid), 32'd0);

    txn("after_rst",  1'b0, 32'h0000_0080, 32'h0,         2'b10, 1'b0, 32'h0BAD_CAFE, 1'b0, 32'h0000_0080, 32'h0,         8'h00, 0, 0, 32'h0BAD_CAFE, 1'b0);

`ifdef LSU_TIMEOUT_EN
    begin
      int   n;
      exp_t got;
      exp_t e;
      @(negedge clk);
      req_valid = 1'b1;
      req_wen   = 1'b0;
      req_addr  = 32'h0000_0100;
      req_size  = 2'b10;
      e.rdata   = 32'h0;
      e.err     = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      req_valid     = 1'b0;
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      n = 0;
      while (resp_valid !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("tmo:wait_cycles", 32'(n), 32'd16);
      got = sb.pop_front();
      chk("tmo:resp_err", 32'(resp_err), 32'(got.err));
      chk("tmo:resp_rdata", resp_rdata, got.rdata);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready    = 1'b0;
      mem_rsp_valid = 1'b1;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      chk("tmo:stray_rsp", 32'(resp_valid), 32'd0);
    end
`endif

    chk("sb:drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit between the core's decode/execute stage and data memory. It replaces the fixed-latency negedge memory access with a registered valid/ready handshake on both sides. It handles byte-lane steering, write-mask generation, load sign/zero extension and misalignment detection. Upstream is the IDU/EXU address and data path; downstream is the data-memory bus model.

Parameters:
TIMEOUT, 16, cycles allowed in WAIT before an error response (used only with LSU_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  1  core presents a load/store request
req_ready  out  1  LSU can accept a request
req_wen  in  1  1=store, 0=load
req_addr  in  32  byte address (ALU result)
req_wdata  in  32  store data, right-aligned
req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
resp_valid  out  1  response available
resp_ready  in  1  core consumes the response
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, illegal size, or timeout
mem_req_valid  out  1  bus request
mem_req_ready  in  1  bus accepts the request
mem_wen  out  1  bus write
mem_addr  out  32  word-aligned address {req_addr[31:2],2'b00}
mem_wdata  out  32  lane-shifted store data
mem_wmask  out  8  byte mask, bits [7:4] always 0
mem_rsp_valid  in  1  bus response; single-cycle pulse
mem_rdata  in  32  bus read word

Behaviour:
- Reset: clk/rst as above; rst is synchronous and active-high. While rst=1 and on the first cycle after it drops: state=IDLE; all outputs 0 except req_ready=1 in IDLE after rst=0. req_ready=0 while rst=1.
- FSM states: IDLE, REQ, WAIT, RESP. All outputs are decoded from state and captured registers (Moore); no combinational path from inputs to outputs.
- IDLE: req_ready=1. On req_valid:
  - Capture wen, addr, wdata, size, unsigned.
  - Misalignment check: half with addr[0]=1, word with addr[1:0]!=0, or size=11. If misaligned → RESP with err=1, rdata=0, and no bus access.
  - Otherwise → REQ.
- REQ: mem_req_valid=1. mem_addr, mem_wen, mem_wdata and mem_wmask stay stable until mem_req_ready=1, then → WAIT.
- WAIT: mem_rsp_valid is sampled only in this state; it is ignored in every other state, including in the REQ acceptance cycle. On mem_rsp_valid:
  - Load: capture the extracted data.
  - Store: capture 0.
  - → RESP.
- RESP: resp_valid=1 held until resp_ready=1, then → IDLE. A new request cannot be accepted in the same cycle (req_ready=0 in RESP).
- Lane steering: off=addr[1:0].
  - mem_wdata = req_wdata << (8*off).
  - mem_wmask: byte = 4'b0001<<off; half = 4'b0011<<off; word = 4'b1111; zero-extended to 8 bits.
  - Loads: mem_wmask=0.
- Load extract: w = mem_rdata >> (8*off). Byte uses w[7:0]; half uses w[15:0]; each is sign- or zero-extended to 32 bits per req_unsigned. Word returns mem_rdata unchanged.
- Minimum latency with mem_req_ready=1 and the response on the next cycle: accept at C0, REQ C1, WAIT C2, resp_valid at C3.
- Reset mid-operation from any state: return to IDLE on the next edge. mem_req_valid and resp_valid drop; the in-flight response is discarded. A late mem_rsp_valid in IDLE has no effect.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: a counter clears on entering WAIT and increments each WAIT cycle. When it reaches TIMEOUT with no mem_rsp_valid → RESP with err=1, rdata=0. A later stray mem_rsp_valid is ignored.
- Undefined: no counter is built, and WAIT waits indefinitely.

Test Plan:
- Aligned word load at addr 0x80000004 with mem_rdata=0xDEADBEEF and ready/response immediate → mem_addr=0x80000004, resp_valid at C3, resp_rdata=0xDEADBEEF, err=0.
- Signed byte load at addr 0x80000003 with mem_rdata=0x80112233 → resp_rdata=0xFFFFFF80; the same load with req_unsigned=1 → 0x00000080.
- Half store of wdata 0x0000ABCD at addr 0x80000002 → mem_wdata=0xABCD0000, mem_wmask=8'h0C, mem_wen=1, resp_rdata=0.
- Word load at addr 0x80000006 → resp_err=1 one cycle after accept, mem_req_valid never asserted.
- mem_req_ready low for 5 cycles and resp_ready low for 3 cycles → request fields stable throughout, resp_valid held, exactly one transaction completes.
- rst pulsed during WAIT, then mem_rsp_valid arrives → no resp_valid. With LSU_TIMEOUT_EN and TIMEOUT=16 and no response → resp_err=1 after 16 WAIT cycles.
